// File: rtl/kore_opsched.sv
// rtl/kore_opsched.sv - two-requester op scheduler: 4-deep tagged FIFO feeding a one-op-at-a-time issue FSM
//
// Optional feature: define KORE_OPSCHED_TIMEOUT_EN to abort an op after 64 cycles in WAIT
// without eop (err pulses with the done pulse). Without it err is tied low and WAIT is unbounded.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req0_valid/data/ready         requester 0 op handshake (25-bit op word)
//   req1_valid/data/ready         requester 1 op handshake (25-bit op word)
//   opcode, pcdata_rs0/rs1/rd/bc  fields of the op in flight (registered, held ISSUE..DONE)
//   opflag                        one-cycle start strobe to the functional FSM
//   eop                           end-of-operation level from the functional FSM
//   done0, done1                  one-cycle completion pulse to the owning requester
//   busy                          scheduler not idle
//   level                         FIFO occupancy 0..4
//   err                           timeout pulse (coincides with the done pulse)
module kore_opsched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [24:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [24:0] req1_data,
  output logic        req1_ready,
  output logic [6:0]  opcode,
  output logic [4:0]  pcdata_rs0,
  output logic [4:0]  pcdata_rs1,
  output logic [4:0]  pcdata_rd,
  output logic [2:0]  pcdata_bc,
  output logic        opflag,
  input  logic        eop,
  output logic        done0,
  output logic        done1,
  output logic        busy,
  output logic [2:0]  level,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;

  // Each entry is {tag, op word}; tag 1 means the op came from requester 1.
  logic [25:0] fifo_mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        prio;      // 0: req0 wins a tie, 1: req1 wins a tie
  logic        cur_tag;   // owner of the op in flight

  logic        pop;
  logic        can_push;
  logic        grant0;
  logic        grant1;
  logic        push;
  logic [25:0] push_word;
  logic [25:0] head;
  logic        timeout;

  // The head entry leaves the FIFO during the DONE cycle, so a full FIFO
  // can still accept a new op in that same cycle.
  assign pop      = (state == DONE);
  assign can_push = (count != 3'd4) || pop;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && can_push) begin
      if (req0_valid && (!req1_valid || !prio)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign push       = grant0 || grant1;
  assign push_word  = grant0 ? {1'b0, req0_data} : {1'b1, req1_data};
  assign head       = fifo_mem[rd_ptr];
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign level      = count;

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
      prio   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (grant0) begin
        prio <= 1'b1;
      end else if (grant1) begin
        prio <= 1'b0;
      end
    end
  end

`ifdef KORE_OPSCHED_TIMEOUT_EN
  logic [5:0] wait_cnt;
  logic       err_r;

  // wait_cnt is 0 during the first WAIT cycle, so it reads 63 in the 64th.
  assign timeout = (state == WAIT) && !eop && (wait_cnt == 6'd63);
  assign err     = err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 6'd0;
      err_r    <= 1'b0;
    end else begin
      err_r <= timeout;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 6'd1;
      end else begin
        wait_cnt <= 6'd0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      opflag     <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      cur_tag    <= 1'b0;
      opcode     <= 7'd0;
      pcdata_rs0 <= 5'd0;
      pcdata_rs1 <= 5'd0;
      pcdata_rd  <= 5'd0;
      pcdata_bc  <= 3'd0;
    end else begin
      opflag <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      case (state)
        IDLE: begin
          // A stale eop from the previous op holds off the next issue.
          if ((count != 3'd0) && !eop) begin
            state      <= ISSUE;
            opflag     <= 1'b1;
            cur_tag    <= head[25];
            opcode     <= head[24:18];
            pcdata_rs0 <= head[17:13];
            pcdata_rs1 <= head[12:8];
            pcdata_rd  <= head[7:3];
            pcdata_bc  <= head[2:0];
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (eop || timeout) begin
            state <= DONE;
            done0 <= !cur_tag;
            done1 <= cur_tag;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kore_opsched.sv
// tb/tb_kore_opsched.sv - scenario tests plus randomized comparison against a queue-based scheduler model
module tb_kore_opsched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [24:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [24:0] req1_data = '0;
  logic        req1_ready;
  logic [6:0]  opcode;
  logic [4:0]  pcdata_rs0;
  logic [4:0]  pcdata_rs1;
  logic [4:0]  pcdata_rd;
  logic [2:0]  pcdata_bc;
  logic        opflag;
  logic        eop = 1'b0;
  logic        done0;
  logic        done1;
  logic        busy;
  logic [2:0]  level;
  logic        err;

  int checks = 0;
  int errors = 0;

  kore_opsched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .opcode     (opcode),
    .pcdata_rs0 (pcdata_rs0),
    .pcdata_rs1 (pcdata_rs1),
    .pcdata_rd  (pcdata_rd),
    .pcdata_bc  (pcdata_bc),
    .opflag     (opflag),
    .eop        (eop),
    .done0      (done0),
    .done1      (done1),
    .busy       (busy),
    .level      (level),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Reference model: queue of pending {tag, word}; phase 0 idle, 1 issue, 2 wait, 3 done.
  logic [25:0] m_q[$];
  bit          m_prio;
  int          m_phase;
  logic [25:0] m_cur;
  bit          m_opflag, m_done0, m_done1, m_err;
  int          m_wcnt;

  task automatic model_reset();
    m_q.delete();
    m_prio = 0; m_phase = 0; m_cur = '0;
    m_opflag = 0; m_done0 = 0; m_done1 = 0; m_err = 0; m_wcnt = 0;
  endtask

  function automatic bit exp_ready(input int who);
    bit can;
    can = (m_q.size() < 4) || (m_phase == 3);
    if (rst || !can) return 1'b0;
    if (who == 0) return req0_valid && (!req1_valid || m_prio == 0);
    return req1_valid && (!req0_valid || m_prio == 1);
  endfunction

  function automatic logic [24:0] fields();
    return {opcode, pcdata_rs0, pcdata_rs1, pcdata_rd, pcdata_bc};
  endfunction

  // Advance one clock; model consumes the inputs as they stood before the edge.
  task automatic step();
    bit g0, g1, pop, eop_s;
    int sz;
    logic [24:0] d0, d1;
    g0 = exp_ready(0); g1 = exp_ready(1);
    pop = (m_phase == 3); sz = m_q.size(); eop_s = eop;
    d0 = req0_data; d1 = req1_data;
    @(posedge clk);
    m_opflag = 0; m_done0 = 0; m_done1 = 0; m_err = 0;
    case (m_phase)
      0: if (sz > 0 && !eop_s) begin m_phase = 1; m_cur = m_q[0]; m_opflag = 1; end
      1: begin m_phase = 2; m_wcnt = 0; end
      2: begin
        if (eop_s) begin
          m_phase = 3; m_done0 = !m_cur[25]; m_done1 = m_cur[25];
        end
`ifdef KORE_OPSCHED_TIMEOUT_EN
        else if (m_wcnt == 63) begin
          m_phase = 3; m_done0 = !m_cur[25]; m_done1 = m_cur[25]; m_err = 1;
        end else m_wcnt++;
`endif
      end
      default: m_phase = 0;
    endcase
    if (pop) void'(m_q.pop_front());
    if (g0) begin m_q.push_back({1'b0, d0}); m_prio = 1; end
    if (g1) begin m_q.push_back({1'b1, d1}); m_prio = 0; end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0; eop = 0; req0_data = '0; req1_data = '0;
    repeat (2) @(posedge clk);
    #1; rst = 0; model_reset();
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1; eop = 0;
    req0_data = 25'($urandom); req1_data = 25'($urandom);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if ({busy, opflag, done0, done1, err} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {busy, opflag, done0, done1, err}); end
    checks++; if (fields() !== 25'd0) begin errors++; $display("FAIL reset_fields got %h exp 0", fields()); end
    rst = 0; req0_valid = 0; req1_valid = 0; model_reset();
  endtask

  task automatic test_single_op();
    logic [24:0] w;
    int ndone;
    do_reset();
    w = {7'h02, 5'd1, 5'd2, 5'd3, 3'd0};
    req0_data = w; req0_valid = 1; #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", req0_ready); end
    step();
    req0_valid = 0; req0_data = 25'($urandom);
    checks++; if (level !== 3'd1 || opflag !== 1'b0) begin errors++; $display("FAIL single_accept level %0d opflag %b exp 1 0", level, opflag); end
    step();
    checks++; if (opflag !== 1'b1) begin errors++; $display("FAIL single_opflag got %b exp 1", opflag); end
    checks++; if (fields() !== w) begin errors++; $display("FAIL single_fields got %h exp %h", fields(), w); end
    ndone = 0;
    for (int k = 1; k <= 6; k++) begin
      eop = (k == 4);
      step();
      if (done0) ndone++;
      checks++; if (opflag !== 1'b0) begin errors++; $display("FAIL single_opflag_len k %0d got %b exp 0", k, opflag); end
      checks++; if (fields() !== w) begin errors++; $display("FAIL single_stable k %0d got %h exp %h", k, fields(), w); end
      checks++; if (done0 !== (k == 4) || done1 !== 1'b0) begin errors++; $display("FAIL single_done k %0d got %b%b exp %b0", k, done0, done1, (k == 4)); end
    end
    eop = 0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL single_done_count got %0d exp 1", ndone); end
    checks++; if (level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_end level %0d busy %b exp 0 0", level, busy); end
  endtask

  task automatic test_contention();
    bit gq[$];
    bit dq[$];
    int n0, n1, maxlvl;
    bit g0, g1;
    do_reset();
    n0 = 0; n1 = 0; maxlvl = 0;
    req0_valid = 1; req1_valid = 1;
    req0_data = 25'($urandom); req1_data = 25'($urandom);
    for (int cyc = 0; cyc < 200 && dq.size() < 8; cyc++) begin
      eop = (m_phase == 2);
      #1;
      g0 = req0_valid && req0_ready; g1 = req1_valid && req1_ready;
      checks++; if ({req0_ready, req1_ready} !== {exp_ready(0), exp_ready(1)}) begin errors++; $display("FAIL cont_ready cyc %0d got %b%b exp %b%b", cyc, req0_ready, req1_ready, exp_ready(0), exp_ready(1)); end
      step();
      if (g0) begin gq.push_back(0); n0++; req0_data = 25'($urandom); if (n0 == 4) req0_valid = 0; end
      if (g1) begin gq.push_back(1); n1++; req1_data = 25'($urandom); if (n1 == 4) req1_valid = 0; end
      if (done0) dq.push_back(0);
      if (done1) dq.push_back(1);
      if (int'(level) > maxlvl) maxlvl = int'(level);
      if (opflag) begin
        checks++; if (fields() !== m_cur[24:0]) begin errors++; $display("FAIL cont_fields got %h exp %h", fields(), m_cur[24:0]); end
      end
    end
    eop = 0;
    checks++; if (gq.size() != 8 || dq.size() != 8) begin errors++; $display("FAIL cont_counts grants %0d dones %0d exp 8 8", gq.size(), dq.size()); end
    for (int i = 0; i < gq.size() && i < 8; i++) begin
      checks++; if (gq[i] != bit'(i % 2)) begin errors++; $display("FAIL cont_grant_order idx %0d got %0d exp %0d", i, gq[i], i % 2); end
    end
    for (int i = 0; i < dq.size() && i < 8; i++) begin
      checks++; if (dq[i] != bit'(i % 2)) begin errors++; $display("FAIL cont_done_order idx %0d got %0d exp %0d", i, dq[i], i % 2); end
    end
    checks++; if (maxlvl > 4) begin errors++; $display("FAIL cont_maxlevel got %0d exp <=4", maxlvl); end
  endtask

  task automatic test_full();
    do_reset();
    eop = 0;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_data = 25'($urandom); req1_data = 25'($urandom);
      step();
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", level); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b%b exp 00", req0_ready, req1_ready); end
    eop = 1;
    step();
    eop = 0;
    checks++; if (done0 !== m_done0 || done1 !== m_done1 || (done0 | done1) !== 1'b1) begin errors++; $display("FAIL full_done got %b%b exp %b%b", done0, done1, m_done0, m_done1); end
    checks++; if ((req0_ready | req1_ready) !== 1'b1 || {req0_ready, req1_ready} !== {exp_ready(0), exp_ready(1)}) begin errors++; $display("FAIL full_pop_ready got %b%b exp %b%b", req0_ready, req1_ready, exp_ready(0), exp_ready(1)); end
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_pushpop_level got %0d exp 4", level); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL full_ready_again got %b%b exp 00", req0_ready, req1_ready); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_stale_eop();
    do_reset();
    req1_valid = 1; req1_data = 25'($urandom);
    step();
    req1_data = 25'($urandom);
    step();
    req1_valid = 0;
    for (int i = 0; i < 10 && m_phase != 2; i++) step();
    eop = 1;
    step();
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL stale_done1 got %b exp 1", done1); end
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (busy !== 1'b0 || opflag !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL stale_hold i %0d busy %b opflag %b level %0d exp 0 0 1", i, busy, opflag, level); end
    end
    eop = 0;
    step();
    checks++; if (opflag !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL stale_release opflag %b busy %b exp 1 1", opflag, busy); end
    checks++; if (fields() !== m_cur[24:0]) begin errors++; $display("FAIL stale_fields got %h exp %h", fields(), m_cur[24:0]); end
  endtask

  task automatic test_reset_mid_wait();
    int nd;
    bit seen;
    do_reset();
    eop = 0;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_data = 25'($urandom);
      step();
    end
    req0_valid = 0;
    step();
    checks++; if (level !== 3'd3 || busy !== 1'b1 || m_phase != 2) begin errors++; $display("FAIL rstwait_pre level %0d busy %b exp 3 1", level, busy); end
    req0_valid = 1;
    #2; rst = 1; #1;
    checks++; if (level !== 3'd0 || {busy, opflag, done0, done1, err} !== 5'b0) begin errors++; $display("FAIL rstwait_async level %0d flags %b exp 0 00000", level, {busy, opflag, done0, done1, err}); end
    checks++; if (fields() !== 25'd0 || req0_ready !== 1'b0) begin errors++; $display("FAIL rstwait_fields got %h ready %b exp 0 0", fields(), req0_ready); end
    nd = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (done0 || done1) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL rstwait_nodone got %0d exp 0", nd); end
    rst = 0; req0_valid = 0; model_reset();
    req1_valid = 1; req1_data = 25'($urandom);
    step();
    req1_valid = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      eop = (m_phase == 2);
      step();
      if (done1) seen = 1;
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rstwait_done0 got %b exp 0", done0); end
    end
    eop = 0;
    checks++; if (!seen) begin errors++; $display("FAIL rstwait_service done1 got 0 exp 1"); end
    checks++; if (fields() !== m_cur[24:0]) begin errors++; $display("FAIL rstwait_fields2 got %h exp %h", fields(), m_cur[24:0]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req0_valid = 1'($urandom_range(0, 1)); req0_data = 25'($urandom);
      req1_valid = 1'($urandom_range(0, 1)); req1_data = 25'($urandom);
      eop = ($urandom_range(0, 3) == 0);
      #1;
      checks++; if (req0_ready !== exp_ready(0)) begin errors++; $display("FAIL rand_ready0 cyc %0d got %b exp %b", i, req0_ready, exp_ready(0)); end
      checks++; if (req1_ready !== exp_ready(1)) begin errors++; $display("FAIL rand_ready1 cyc %0d got %b exp %b", i, req1_ready, exp_ready(1)); end
      step();
      checks++; if (level !== 3'(m_q.size())) begin errors++; $display("FAIL rand_level cyc %0d got %0d exp %0d", i, level, m_q.size()); end
      checks++; if (busy !== (m_phase != 0)) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", i, busy, (m_phase != 0)); end
      checks++; if ({opflag, done0, done1, err} !== {m_opflag, m_done0, m_done1, m_err}) begin errors++; $display("FAIL rand_pulses cyc %0d got %b exp %b", i, {opflag, done0, done1, err}, {m_opflag, m_done0, m_done1, m_err}); end
      checks++; if (fields() !== m_cur[24:0]) begin errors++; $display("FAIL rand_fields cyc %0d got %h exp %h", i, fields(), m_cur[24:0]); end
    end
    req0_valid = 0; req1_valid = 0; eop = 0;
  endtask

`ifdef KORE_OPSCHED_TIMEOUT_EN
  task automatic test_timeout();
    int t_issue, t_done;
    bit errseen, reissue;
    do_reset();
    eop = 0;
    for (int i = 0; i < 2; i++) begin
      req0_valid = 1; req0_data = 25'($urandom);
      step();
    end
    req0_valid = 0;
    t_issue = -1; t_done = -1; errseen = 0; reissue = 0;
    for (int c = 0; c < 200 && !reissue; c++) begin
      step();
      if (opflag && t_issue < 0) t_issue = c;
      else if (opflag && t_done >= 0) reissue = 1;
      if (done0 && t_done < 0) begin t_done = c; errseen = err; end
      checks++; if (err !== m_err) begin errors++; $display("FAIL tmo_err cyc %0d got %b exp %b", c, err, m_err); end
    end
    checks++; if (t_done - t_issue != 65) begin errors++; $display("FAIL tmo_latency got %0d exp 65", t_done - t_issue); end
    checks++; if (!errseen) begin errors++; $display("FAIL tmo_err_with_done got 0 exp 1"); end
    checks++; if (!reissue) begin errors++; $display("FAIL tmo_next_issue got 0 exp 1"); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_full();
    test_stale_eop();
    test_reset_mid_wait();
    test_random();
`ifdef KORE_OPSCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
